// File: rtl/bsg_up_piso_credit_if.sv
// Core-side handshake and I/O-side beat/credit signals of the upstream PISO.
// Signal names match the original port list of the serializer.
interface bsg_up_piso_credit_if #(
    parameter int CORE_W  = 64,
    parameter int CH_NUM  = 2,
    parameter int CH_W    = 8,
    parameter int CREDITS = 16,
    parameter int SENT_W  = 7
);
    localparam int IO_W   = CH_NUM * CH_W;
    localparam int CRED_W = $clog2(CREDITS + 1);

    logic                core_valid_i;
    logic [CORE_W-1:0]   core_data_i;
    logic                core_ready_o;
    logic                io_valid_o;
    logic [IO_W-1:0]     io_data_o;
    logic                io_token_i;
    logic [CRED_W-1:0]   credit_o;
    logic [SENT_W-1:0]   sent_cnt_o;
    logic                busy_o;
    logic                credit_err_o;

    modport master (
        output core_valid_i, core_data_i, io_token_i,
        input  core_ready_o, io_valid_o, io_data_o, credit_o,
               sent_cnt_o, busy_o, credit_err_o
    );

    modport slave (
        input  core_valid_i, core_data_i, io_token_i,
        output core_ready_o, io_valid_o, io_data_o, credit_o,
               sent_cnt_o, busy_o, credit_err_o
    );
endinterface

// File: rtl/bsg_up_piso_credit.sv
// Upstream serializer: small input FIFO feeding a shift register that emits
// CH_NUM x CH_W beats, LSB slice first, gated by a credit pool.
module bsg_up_piso_credit #(
    parameter int CORE_W        = 64,
    parameter int CH_NUM        = 2,
    parameter int CH_W          = 8,
    parameter int DEPTH         = 2,
    parameter int CREDITS       = 16,
    parameter int TOKEN_CREDITS = 8,
    parameter int SENT_W        = 7
) (
    input logic                 clk,
    input logic                 rst,
    bsg_up_piso_credit_if.slave bus
);
    localparam int IO_W   = CH_NUM * CH_W;
    localparam int BEATS  = CORE_W / IO_W;
    localparam int CRED_W = $clog2(CREDITS + 1);
    localparam int SUM_W  = CRED_W + 1;
    localparam int PTR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W  = $clog2(DEPTH + 1);
    localparam int IDX_W  = $clog2(BEATS);

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t              state;
    logic [CORE_W-1:0]   mem [DEPTH];
    logic [PTR_W-1:0]    wr_ptr, rd_ptr;
    logic [CNT_W-1:0]    count;
    logic [CORE_W-1:0]   shreg;
    logic [IDX_W-1:0]    beat_idx;
    logic [CRED_W-1:0]   credit;
    logic [SENT_W-1:0]   sent_cnt;
    logic                credit_err;

    logic                fifo_ready, fifo_nonempty, push, pop;
    logic                emit, last, load;
    logic [SUM_W-1:0]    credit_sum;

    always_comb begin
        fifo_ready    = count < CNT_W'(DEPTH);
        fifo_nonempty = count != '0;
        push          = bus.core_valid_i && fifo_ready;
        emit          = (state == SHIFT) && (credit != '0);
        last          = beat_idx == IDX_W'(BEATS - 1);
        // Reload on the final beat's edge keeps back-to-back words gapless.
        load          = fifo_nonempty && ((state == IDLE) || (emit && last));
        pop           = load;
        credit_sum    = SUM_W'(credit) - SUM_W'(emit)
                      + (bus.io_token_i ? SUM_W'(TOKEN_CREDITS) : '0);
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= bus.core_data_i;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= (wr_ptr == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= (rd_ptr == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
            end
            count <= count + CNT_W'(push) - CNT_W'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            shreg    <= '0;
            beat_idx <= '0;
        end else if (load) begin
            state    <= SHIFT;
            shreg    <= mem[rd_ptr];
            beat_idx <= '0;
        end else if (emit) begin
            shreg    <= shreg >> IO_W;
            beat_idx <= beat_idx + 1'b1;
            if (last) begin
                state <= IDLE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            credit     <= CRED_W'(CREDITS);
            credit_err <= 1'b0;
            sent_cnt   <= '0;
        end else begin
            if (credit_sum > SUM_W'(CREDITS)) begin
                credit     <= CRED_W'(CREDITS);
                credit_err <= 1'b1;
            end else begin
                credit <= credit_sum[CRED_W-1:0];
            end
            sent_cnt <= sent_cnt + SENT_W'(emit);
        end
    end

    assign bus.core_ready_o = fifo_ready;
    assign bus.io_valid_o   = emit;
    assign bus.io_data_o    = shreg[IO_W-1:0];
    assign bus.credit_o     = credit;
    assign bus.sent_cnt_o   = sent_cnt;
    assign bus.busy_o       = (state == SHIFT);
    assign bus.credit_err_o = credit_err;
endmodule

// File: tb/tb_bsg_up_piso_credit.sv
// Scoreboard bench for bsg_up_piso_credit: expected beats are queued when a
// word is driven and compared as the DUT emits them.
module tb_bsg_up_piso_credit;
    logic clk;
    logic rst;

    int n_checks = 0;
    int n_fail   = 0;
    logic [15:0] exp_q[$];
    logic saw_full = 1'b0;

    bsg_up_piso_credit_if #(
        .CORE_W(64), .CH_NUM(2), .CH_W(8), .CREDITS(16), .SENT_W(7)
    ) bus ();

    bsg_up_piso_credit #(
        .CORE_W(64), .CH_NUM(2), .CH_W(8), .DEPTH(2),
        .CREDITS(16), .TOKEN_CREDITS(8), .SENT_W(7)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Beat monitor: samples mid-cycle, away from the active edge.
    always @(negedge clk) begin
        if (bus.io_valid_o === 1'b1) begin
            check("beat_expected", 64'(exp_q.size() != 0), 64'd1);
            if (exp_q.size() != 0) begin
                check("beat_data", 64'(bus.io_data_o), 64'(exp_q.pop_front()));
            end
        end
    end

    task automatic wait_sample();
        @(negedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        exp_q.delete();
    endtask

    task automatic push_word(input logic [63:0] w);
        int unsigned waited = 0;
        for (int i = 0; i < 4; i++) exp_q.push_back(w[i*16 +: 16]);
        bus.core_valid_i = 1'b1;
        bus.core_data_i  = w;
        while (!bus.core_ready_o && waited < 200) begin
            saw_full = 1'b1;
            @(posedge clk);
            #1;
            waited++;
        end
        check("push_ready", 64'(bus.core_ready_o), 64'd1);
        @(posedge clk);
        #1;
        bus.core_valid_i = 1'b0;
    endtask

    task automatic pulse_token();
        @(posedge clk);
        #1;
        bus.io_token_i = 1'b1;
        @(posedge clk);
        #1;
        bus.io_token_i = 1'b0;
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_ready"},  64'(bus.core_ready_o), 64'd1);
        check({tag, "_valid"},  64'(bus.io_valid_o),   64'd0);
        check({tag, "_data"},   64'(bus.io_data_o),    64'd0);
        check({tag, "_credit"}, 64'(bus.credit_o),     64'd16);
        check({tag, "_sent"},   64'(bus.sent_cnt_o),   64'd0);
        check({tag, "_busy"},   64'(bus.busy_o),       64'd0);
        check({tag, "_err"},    64'(bus.credit_err_o), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic found;
        rst = 1'b1;
        bus.core_valid_i = 1'b0;
        bus.core_data_i  = '0;
        bus.io_token_i   = 1'b0;

        // Reset values
        do_reset();
        wait_sample();
        check_reset_values("rst0");

        // Single word, full credits: valid in cycles 2..5 after acceptance
        do_reset();
        push_word(64'h0807060504030201);
        wait_sample();
        check("t1_lat_valid", 64'(bus.io_valid_o), 64'd0);
        for (int c = 0; c < 4; c++) begin
            wait_sample();
            check("t1_beat_valid", 64'(bus.io_valid_o), 64'd1);
        end
        wait_sample();
        check("t1_end_valid",  64'(bus.io_valid_o), 64'd0);
        check("t1_end_sent",   64'(bus.sent_cnt_o), 64'd4);
        check("t1_end_credit", 64'(bus.credit_o),   64'd12);
        check("t1_end_busy",   64'(bus.busy_o),     64'd0);

        // Five words back-to-back, no tokens: stall at credit 0
        do_reset();
        saw_full = 1'b0;
        for (int k = 0; k < 5; k++) push_word({$urandom, $urandom});
        found = 1'b0;
        for (int c = 0; c < 200 && !found; c++) begin
            wait_sample();
            if (bus.credit_o == '0 && !bus.io_valid_o) found = 1'b1;
        end
        check("t2_stall_reached", 64'(found), 64'd1);
        check("t2_saw_full",  64'(saw_full),          64'd1);
        check("t2_sent",      64'(bus.sent_cnt_o),    64'd16);
        check("t2_busy",      64'(bus.busy_o),        64'd1);
        check("t2_ready",     64'(bus.core_ready_o),  64'd1);
        check("t2_pending",   64'(exp_q.size()),      64'd4);

        // Token from the stall: the token cycle itself still emits nothing
        @(posedge clk);
        #1;
        bus.io_token_i = 1'b1;
        wait_sample();
        check("t3_token_cycle_valid", 64'(bus.io_valid_o), 64'd0);
        @(posedge clk);
        #1;
        bus.io_token_i = 1'b0;
        wait_sample();
        check("t3_credit_after_token", 64'(bus.credit_o),   64'd8);
        check("t3_valid_after_token",  64'(bus.io_valid_o), 64'd1);
        for (int c = 0; c < 3; c++) begin
            wait_sample();
            check("t3_beat_valid", 64'(bus.io_valid_o), 64'd1);
        end
        wait_sample();
        check("t3_end_valid",  64'(bus.io_valid_o), 64'd0);
        check("t3_end_credit", 64'(bus.credit_o),   64'd4);
        check("t3_end_sent",   64'(bus.sent_cnt_o), 64'd20);
        check("t3_end_busy",   64'(bus.busy_o),     64'd0);

        // Token netted with an emitted beat at credit 5
        pulse_token();
        wait_sample();
        check("t4_refill", 64'(bus.credit_o), 64'd12);
        push_word(64'h1111_2222_3333_4444);
        push_word(64'h5555_6666_7777_8888);
        found = 1'b0;
        for (int c = 0; c < 40 && !found; c++) begin
            wait_sample();
            if (bus.credit_o == 5 && bus.io_valid_o) found = 1'b1;
        end
        check("t4_credit5_reached", 64'(found), 64'd1);
        bus.io_token_i = 1'b1;
        @(posedge clk);
        #1;
        bus.io_token_i = 1'b0;
        wait_sample();
        check("t4_netted_credit", 64'(bus.credit_o),     64'd12);
        check("t4_no_err",        64'(bus.credit_err_o), 64'd0);

        // Token at full credit: clamp and sticky error
        do_reset();
        wait_sample();
        check_reset_values("rst1");
        pulse_token();
        wait_sample();
        check("t5_clamped", 64'(bus.credit_o),     64'd16);
        check("t5_err",     64'(bus.credit_err_o), 64'd1);
        repeat (5) @(posedge clk);
        wait_sample();
        check("t5_err_sticky", 64'(bus.credit_err_o), 64'd1);
        do_reset();
        wait_sample();
        check("t5_err_cleared", 64'(bus.credit_err_o), 64'd0);

        // Reset after beat 1 of a word
        push_word(64'h0807060504030201);
        wait_sample();
        wait_sample();
        wait_sample();
        check("t6_mid_word_busy", 64'(bus.busy_o), 64'd1);
        rst = 1'b1;
        exp_q.delete();
        @(posedge clk);
        #1;
        rst = 1'b0;
        wait_sample();
        check_reset_values("t6_rst");
        push_word(64'h0807060504030201);
        repeat (7) wait_sample();
        check("t6_fresh_sent", 64'(bus.sent_cnt_o), 64'd4);
        check("t6_fresh_busy", 64'(bus.busy_o),     64'd0);

        check("queue_drained", 64'(exp_q.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
